// File: rtl/pcie_dn_dispatch.sv
// pcie_dn_dispatch: routes the PCIe RX packet stream to CH0/CH1 by SOP channel field, with drop/error counters
module pcie_dn_dispatch #(
  parameter int P_CH_LSB = 56,
  parameter int P_CNT_W  = 16
) (
  input  logic               PCIE_CLK,
  input  logic               PCIE_RST,
  input  logic               DNK_RX_DVLD,
  output logic               DNK_RX_RDY,
  input  logic [63:0]        DNK_RX_DATA,
  input  logic [1:0]         DNK_RX_MASK,
  input  logic               DNK_RX_SOP,
  input  logic               DNK_RX_EOP,
  output logic               DNK_TX0_DVLD,
  input  logic               DNK_TX0_RDY,
  output logic [63:0]        DNK_TX0_DATA,
  output logic [1:0]         DNK_TX0_MASK,
  output logic               DNK_TX0_SOP,
  output logic               DNK_TX0_EOP,
  output logic               DNK_TX1_DVLD,
  input  logic               DNK_TX1_RDY,
  output logic [63:0]        DNK_TX1_DATA,
  output logic [1:0]         DNK_TX1_MASK,
  output logic               DNK_TX1_SOP,
  output logic               DNK_TX1_EOP,
  output logic [P_CNT_W-1:0] DNK_DROP_CNT,
  output logic [P_CNT_W-1:0] DNK_ERR_CNT
);
  typedef enum logic [1:0] {S_IDLE, S_CH0, S_CH1, S_DROP} state_t;
  state_t state_q, state_d;
  logic [63:0] data_q;
  logic [1:0] mask_q, ch;
  logic sop_q, eop_q, sel_q, vld_q;
  logic in_fire, out_fire, load, sel_d, drop_inc, err_inc;
  logic [P_CNT_W-1:0] drop_q, err_q;
  assign ch = DNK_RX_DATA[P_CH_LSB+:2];
  assign out_fire = vld_q & (sel_q ? DNK_TX1_RDY : DNK_TX0_RDY);
  assign DNK_RX_RDY = ~PCIE_RST & (~vld_q | out_fire);
  assign in_fire = DNK_RX_DVLD & DNK_RX_RDY;
  // An SOP is always decoded as a new packet; outside S_IDLE it also flags the truncated one.
  always_comb begin
    state_d = state_q;
    load = 1'b0;
    sel_d = sel_q;
    drop_inc = 1'b0;
    err_inc = 1'b0;
    if (in_fire) begin
      if (DNK_RX_SOP) begin
        err_inc = state_q != S_IDLE;
        drop_inc = ch[1];
        load = ~ch[1];
        sel_d = ch[0];
        state_d = DNK_RX_EOP ? S_IDLE : ch[1] ? S_DROP : ch[0] ? S_CH1 : S_CH0;
      end else begin
        err_inc = state_q == S_IDLE;
        load = (state_q == S_CH0) | (state_q == S_CH1);
        sel_d = state_q == S_CH1;
        state_d = DNK_RX_EOP ? S_IDLE : state_q;
      end
    end
  end
  always_ff @(posedge PCIE_CLK) begin
    if (PCIE_RST) begin
      state_q <= S_IDLE;
      vld_q <= 1'b0;
      sel_q <= 1'b0;
      data_q <= '0;
      mask_q <= '0;
      sop_q <= 1'b0;
      eop_q <= 1'b0;
      drop_q <= '0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q <= load | (vld_q & ~out_fire);
      if (load) begin
        sel_q <= sel_d;
        data_q <= DNK_RX_DATA;
        mask_q <= DNK_RX_MASK;
        sop_q <= DNK_RX_SOP;
        eop_q <= DNK_RX_EOP;
      end
      drop_q <= drop_q + P_CNT_W'(drop_inc & ~&drop_q);
      err_q <= err_q + P_CNT_W'(err_inc & ~&err_q);
    end
  end
  assign DNK_TX0_DVLD = vld_q & ~sel_q;
  assign DNK_TX1_DVLD = vld_q & sel_q;
  assign DNK_TX0_DATA = data_q;
  assign DNK_TX1_DATA = data_q;
  assign DNK_TX0_MASK = mask_q;
  assign DNK_TX1_MASK = mask_q;
  assign DNK_TX0_SOP = sop_q;
  assign DNK_TX1_SOP = sop_q;
  assign DNK_TX0_EOP = eop_q;
  assign DNK_TX1_EOP = eop_q;
  assign DNK_DROP_CNT = drop_q;
  assign DNK_ERR_CNT = err_q;
endmodule

// File: tb/tb_pcie_dn_dispatch.sv
// tb_pcie_dn_dispatch: table-driven stimulus with a scoreboard of expected routed beats
module tb_pcie_dn_dispatch;
  logic PCIE_CLK, PCIE_RST;
  logic DNK_RX_DVLD, DNK_RX_RDY, DNK_RX_SOP, DNK_RX_EOP;
  logic [63:0] DNK_RX_DATA;
  logic [1:0] DNK_RX_MASK;
  logic DNK_TX0_DVLD, DNK_TX0_RDY, DNK_TX0_SOP, DNK_TX0_EOP;
  logic [63:0] DNK_TX0_DATA;
  logic [1:0] DNK_TX0_MASK;
  logic DNK_TX1_DVLD, DNK_TX1_RDY, DNK_TX1_SOP, DNK_TX1_EOP;
  logic [63:0] DNK_TX1_DATA;
  logic [1:0] DNK_TX1_MASK;
  logic [15:0] DNK_DROP_CNT, DNK_ERR_CNT;

  pcie_dn_dispatch #(.P_CH_LSB(56), .P_CNT_W(16)) dut (
    .PCIE_CLK(PCIE_CLK), .PCIE_RST(PCIE_RST),
    .DNK_RX_DVLD(DNK_RX_DVLD), .DNK_RX_RDY(DNK_RX_RDY), .DNK_RX_DATA(DNK_RX_DATA),
    .DNK_RX_MASK(DNK_RX_MASK), .DNK_RX_SOP(DNK_RX_SOP), .DNK_RX_EOP(DNK_RX_EOP),
    .DNK_TX0_DVLD(DNK_TX0_DVLD), .DNK_TX0_RDY(DNK_TX0_RDY), .DNK_TX0_DATA(DNK_TX0_DATA),
    .DNK_TX0_MASK(DNK_TX0_MASK), .DNK_TX0_SOP(DNK_TX0_SOP), .DNK_TX0_EOP(DNK_TX0_EOP),
    .DNK_TX1_DVLD(DNK_TX1_DVLD), .DNK_TX1_RDY(DNK_TX1_RDY), .DNK_TX1_DATA(DNK_TX1_DATA),
    .DNK_TX1_MASK(DNK_TX1_MASK), .DNK_TX1_SOP(DNK_TX1_SOP), .DNK_TX1_EOP(DNK_TX1_EOP),
    .DNK_DROP_CNT(DNK_DROP_CNT), .DNK_ERR_CNT(DNK_ERR_CNT)
  );

  typedef struct {
    logic [63:0] d;
    logic [1:0]  m;
    logic        sop;
    logic        eop;
    int          route;
  } beat_t;

  beat_t exp_q[$];
  beat_t tbl[18];
  int checks = 0;
  int failures = 0;
  int stalls = 0;

  initial PCIE_CLK = 1'b0;
  always #5 PCIE_CLK = ~PCIE_CLK;

  function automatic beat_t bt(input logic [1:0] ch, input logic [7:0] lo, input logic [1:0] m,
                               input logic sop, input logic eop, input int route);
    beat_t b;
    b.d = '0;
    b.d[57:56] = ch;
    b.d[7:0] = lo;
    b.m = m;
    b.sop = sop;
    b.eop = eop;
    b.route = route;
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic pop(input int ch, input logic [63:0] d, input logic [1:0] m, input logic sop, input logic eop);
    beat_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected ch=%0d data=%0h", ch, d);
    end else begin
      e = exp_q.pop_front();
      if (e.route != ch || e.d !== d || e.m !== m || e.sop !== sop || e.eop !== eop) begin
        failures++;
        $display("FAIL sb_beat actual ch=%0d d=%0h m=%0h sop=%0b eop=%0b expected ch=%0d d=%0h m=%0h sop=%0b eop=%0b",
                 ch, d, m, sop, eop, e.route, e.d, e.m, e.sop, e.eop);
      end
    end
  endtask

  always @(negedge PCIE_CLK) begin
    if (!PCIE_RST && (DNK_TX0_DVLD || DNK_TX1_DVLD)) begin
      chk("one_hot_dvld", {DNK_TX0_DVLD, DNK_TX1_DVLD} == 2'b11, 0);
      if (DNK_TX0_DVLD && DNK_TX0_RDY) pop(0, DNK_TX0_DATA, DNK_TX0_MASK, DNK_TX0_SOP, DNK_TX0_EOP);
      if (DNK_TX1_DVLD && DNK_TX1_RDY) pop(1, DNK_TX1_DATA, DNK_TX1_MASK, DNK_TX1_SOP, DNK_TX1_EOP);
    end
  end

  task automatic send(input beat_t b);
    int w = 0;
    DNK_RX_DVLD = 1'b1;
    DNK_RX_DATA = b.d;
    DNK_RX_MASK = b.m;
    DNK_RX_SOP = b.sop;
    DNK_RX_EOP = b.eop;
    @(negedge PCIE_CLK);
    if (!DNK_RX_RDY) stalls++;
    while (!DNK_RX_RDY && w < 20) begin
      @(negedge PCIE_CLK);
      w++;
    end
    if (!DNK_RX_RDY) begin
      chk("rx_rdy_timeout", 0, 1);
      DNK_RX_DVLD = 1'b0;
      return;
    end
    if (b.route < 2) exp_q.push_back(b);
    @(posedge PCIE_CLK);
    #1;
    if (b.route < 2) begin
      chk("lat_vld", b.route == 1 ? DNK_TX1_DVLD : DNK_TX0_DVLD, 1);
      chk("lat_data", b.route == 1 ? DNK_TX1_DATA : DNK_TX0_DATA, b.d);
    end else begin
      chk("discard_vld", {DNK_TX0_DVLD, DNK_TX1_DVLD}, 0);
    end
    DNK_RX_DVLD = 1'b0;
  endtask

  task automatic run(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send(tbl[i]);
  endtask

  task automatic drain();
    repeat (3) @(posedge PCIE_CLK);
    #1;
    chk("sb_empty", exp_q.size(), 0);
  endtask

  initial begin
    tbl[0]  = bt(0, 8'h11, 2'b11, 1, 0, 0);
    tbl[1]  = bt(0, 8'h22, 2'b11, 0, 0, 0);
    tbl[2]  = bt(0, 8'h33, 2'b11, 0, 0, 0);
    tbl[3]  = bt(0, 8'h44, 2'b01, 0, 1, 0);
    tbl[4]  = bt(1, 8'h55, 2'b10, 1, 1, 1);
    tbl[5]  = bt(0, 8'h66, 2'b11, 1, 0, 0);
    tbl[6]  = bt(0, 8'h77, 2'b11, 0, 0, 0);
    tbl[7]  = bt(0, 8'h88, 2'b01, 0, 1, 0);
    tbl[8]  = bt(3, 8'h99, 2'b11, 1, 0, 2);
    tbl[9]  = bt(0, 8'haa, 2'b11, 0, 0, 2);
    tbl[10] = bt(0, 8'hbb, 2'b11, 0, 1, 2);
    tbl[11] = bt(0, 8'hcc, 2'b11, 1, 1, 0);
    tbl[12] = bt(0, 8'hdd, 2'b11, 0, 0, 2);
    tbl[13] = bt(0, 8'hee, 2'b10, 1, 0, 0);
    tbl[14] = bt(1, 8'hf0, 2'b11, 1, 0, 1);
    tbl[15] = bt(0, 8'hf1, 2'b01, 0, 1, 1);
    tbl[16] = bt(0, 8'h01, 2'b11, 1, 0, 0);
    tbl[17] = bt(2, 8'h02, 2'b11, 1, 1, 2);
    PCIE_RST = 1'b1;
    DNK_RX_DVLD = 1'b0;
    DNK_RX_DATA = '0;
    DNK_RX_MASK = '0;
    DNK_RX_SOP = 1'b0;
    DNK_RX_EOP = 1'b0;
    DNK_TX0_RDY = 1'b1;
    DNK_TX1_RDY = 1'b1;
    repeat (2) @(posedge PCIE_CLK);
    @(negedge PCIE_CLK);
    chk("rst_dvld", {DNK_TX0_DVLD, DNK_TX1_DVLD}, 0);
    chk("rst_fields", {DNK_TX0_DATA, DNK_TX0_MASK, DNK_TX0_SOP, DNK_TX0_EOP}, 0);
    chk("rst_cnts", {DNK_DROP_CNT, DNK_ERR_CNT}, 0);
    chk("rst_rx_rdy", DNK_RX_RDY, 0);
    @(posedge PCIE_CLK);
    #1 PCIE_RST = 1'b0;
    run(0, 3);
    drain();
    chk("t1_cnts", {DNK_DROP_CNT, DNK_ERR_CNT}, 0);
    run(4, 7);
    drain();
    chk("t2_no_stall", stalls, 0);
    chk("t2_cnts", {DNK_DROP_CNT, DNK_ERR_CNT}, 0);
    run(8, 11);
    drain();
    chk("t4_drop", DNK_DROP_CNT, 1);
    chk("t4_err", DNK_ERR_CNT, 0);
    run(12, 15);
    drain();
    chk("t5_err", DNK_ERR_CNT, 2);
    chk("t5_drop", DNK_DROP_CNT, 1);
    run(16, 17);
    drain();
    chk("both_cnt_err", DNK_ERR_CNT, 3);
    chk("both_cnt_drop", DNK_DROP_CNT, 2);
    send(bt(1, 8'h31, 2'b11, 1, 0, 1));
    send(bt(0, 8'h32, 2'b01, 0, 0, 1));
    DNK_TX1_RDY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCIE_CLK);
      chk("bp_hold_vld", DNK_TX1_DVLD, 1);
      chk("bp_hold_data", DNK_TX1_DATA[7:0], 8'h32);
      chk("bp_rx_rdy", DNK_RX_RDY, 0);
    end
    @(posedge PCIE_CLK);
    #1 DNK_TX1_RDY = 1'b1;
    send(bt(0, 8'h33, 2'b10, 0, 1, 1));
    drain();
    PCIE_RST = 1'b1;
    @(posedge PCIE_CLK);
    #1 PCIE_RST = 1'b0;
    DNK_RX_DVLD = 1'b1;
    DNK_RX_SOP = 1'b0;
    DNK_RX_EOP = 1'b0;
    repeat (65534) @(posedge PCIE_CLK);
    #1;
    chk("err_fffe", DNK_ERR_CNT, 16'hfffe);
    @(posedge PCIE_CLK);
    #1;
    chk("err_ffff", DNK_ERR_CNT, 16'hffff);
    @(posedge PCIE_CLK);
    #1;
    chk("err_sat", DNK_ERR_CNT, 16'hffff);
    DNK_RX_DVLD = 1'b0;
    DNK_TX0_RDY = 1'b0;
    send(bt(0, 8'h71, 2'b11, 1, 0, 0));
    PCIE_RST = 1'b1;
    @(negedge PCIE_CLK);
    chk("rst_mid_rx_rdy", DNK_RX_RDY, 0);
    @(posedge PCIE_CLK);
    #1;
    chk("rst_mid_dvld", {DNK_TX0_DVLD, DNK_TX1_DVLD}, 0);
    chk("rst_mid_fields", {DNK_TX0_DATA, DNK_TX0_MASK, DNK_TX0_SOP, DNK_TX0_EOP}, 0);
    chk("rst_mid_cnts", {DNK_DROP_CNT, DNK_ERR_CNT}, 0);
    exp_q.delete();
    PCIE_RST = 1'b0;
    DNK_TX0_RDY = 1'b1;
    send(bt(0, 8'h73, 2'b11, 0, 0, 2));
    chk("post_rst_err", DNK_ERR_CNT, 1);
    send(bt(1, 8'h74, 2'b11, 1, 1, 1));
    drain();
    chk("final_drop", DNK_DROP_CNT, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
